// File: rtl/button_debounce.sv
// Push-button conditioner: synchronizes a raw (possibly active-low) button pin,
// debounces it with a saturating qualification counter, and produces a clean
// active-high level, one-cycle press/release pulses and an 8-bit press counter.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_rise,
  output logic       btn_fall,
  output logic [7:0] press_count
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit so the
  // DEBOUNCE_CYCLES=1 case still has a legal (always-zero) counter.
  localparam int                CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Raw pin level while the button is released.
  localparam logic              IDLE_RAW = ACTIVE_LOW;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample_s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [7:0]             count_q, count_d;
  logic                   accept;

  // Synchronizer chain; reset preloads the idle level so no spurious press
  // is seen while the chain refills after reset.
  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        // First stage samples the asynchronous pin.
        always_ff @(posedge clk) begin
          if (rst) sync_q[gi] <= IDLE_RAW;
          else     sync_q[gi] <= btn_in;
        end
      end else begin : g_rest
        // Later stages resolve metastability from the previous stage.
        always_ff @(posedge clk) begin
          if (rst) sync_q[gi] <= IDLE_RAW;
          else     sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  // Normalised sample: 1 means pressed regardless of pin polarity.
  assign sample_s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  // Next-state logic: qualify disagreements, accept after the full run length.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    count_d = count_q;
    accept  = (sample_s != level_q) && (cnt_q == CNT_LAST);

    if (sample_s == level_q) begin
      cnt_d = '0;                        // agreement (or a bounce) restarts qualification
    end else if (accept) begin
      cnt_d   = '0;
      level_d = sample_s;
      rise_d  = sample_s;
      fall_d  = ~sample_s;
      if (sample_s) count_d = count_q + 8'd1;   // wraps naturally at 256
    end else begin
      cnt_d = cnt_q + CNT_W'(1);         // never reaches past CNT_LAST, so no wrap
    end
  end

  // State register for counter, level, pulses and press count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= 8'd0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_rise    = rise_q;
  assign btn_fall    = fall_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Two instances run side by side: active-low pin and active-high pin driven
// with the inverted stimulus; both must produce identical outputs.
module tb_button_debounce;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       btn_ah;
  logic       lvl_al, rise_al, fall_al;
  logic       lvl_ah, rise_ah, fall_ah;
  logic [7:0] cnt_al, cnt_ah;

  int checks = 0;
  int errors = 0;

  assign btn_ah = ~btn;

  button_debounce #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .btn_in(btn),
    .btn_level(lvl_al), .btn_rise(rise_al), .btn_fall(fall_al), .press_count(cnt_al)
  );

  button_debounce #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2), .ACTIVE_LOW(1'b0)) dut_ah (
    .clk(clk), .rst(rst), .btn_in(btn_ah),
    .btn_level(lvl_ah), .btn_rise(rise_ah), .btn_fall(fall_ah), .press_count(cnt_ah)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Compare every output of both instances against one expected set.
  task automatic chk_all(input string tag, input logic l, input logic r,
                         input logic f, input logic [7:0] c);
    chk({tag, ".level_al"}, {31'd0, lvl_al},  {31'd0, l});
    chk({tag, ".rise_al"},  {31'd0, rise_al}, {31'd0, r});
    chk({tag, ".fall_al"},  {31'd0, fall_al}, {31'd0, f});
    chk({tag, ".count_al"}, {24'd0, cnt_al},  {24'd0, c});
    chk({tag, ".level_ah"}, {31'd0, lvl_ah},  {31'd0, l});
    chk({tag, ".rise_ah"},  {31'd0, rise_ah}, {31'd0, r});
    chk({tag, ".fall_ah"},  {31'd0, fall_ah}, {31'd0, f});
    chk({tag, ".count_ah"}, {24'd0, cnt_ah},  {24'd0, c});
  endtask

  initial begin
    logic [7:0] exp_cnt;

    // Reset with button released.
    btn = 1'b1;
    rst = 1'b1;
    tick(3);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk_all("post_reset_idle", 1'b0, 1'b0, 1'b0, 8'd0);
    end

    // Clean press: accepted at edge 6 after the change.
    btn = 1'b0;
    tick(5);
    chk_all("press_edge5", 1'b0, 1'b0, 1'b0, 8'd0);
    tick(1);
    chk_all("press_edge6", 1'b1, 1'b1, 1'b0, 8'd1);
    tick(1);
    chk_all("press_edge7", 1'b1, 1'b0, 1'b0, 8'd1);
    tick(3);
    chk_all("press_hold", 1'b1, 1'b0, 1'b0, 8'd1);

    // Clean release: btn_fall pulses once, count unchanged.
    btn = 1'b1;
    tick(5);
    chk_all("release_edge5", 1'b1, 1'b0, 1'b0, 8'd1);
    tick(1);
    chk_all("release_edge6", 1'b0, 1'b0, 1'b1, 8'd1);
    tick(1);
    chk_all("release_edge7", 1'b0, 1'b0, 1'b0, 8'd1);

    // Bounce: low 3, high 2, low 3, high -> nothing accepted.
    btn = 1'b0; tick(3);
    btn = 1'b1; tick(2);
    btn = 1'b0; tick(3);
    btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk_all("bounce_quiet", 1'b0, 1'b0, 1'b0, 8'd1);
    end

    // Then a steady low of exactly the qualification length is accepted.
    btn = 1'b0;
    tick(5);
    chk_all("bounce_press_edge5", 1'b0, 1'b0, 1'b0, 8'd1);
    tick(1);
    chk_all("bounce_press_edge6", 1'b1, 1'b1, 1'b0, 8'd2);
    btn = 1'b1;
    tick(6);
    chk_all("bounce_release", 1'b0, 1'b0, 1'b1, 8'd2);

    // Wrap: keep pressing until the counter passes 255 -> 0.
    exp_cnt = 8'd2;
    for (int p = 0; p < 254; p++) begin
      exp_cnt = exp_cnt + 8'd1;
      btn = 1'b0;
      tick(6);
      chk_all("wrap_press", 1'b1, 1'b1, 1'b0, exp_cnt);
      btn = 1'b1;
      tick(6);
      chk_all("wrap_release", 1'b0, 1'b0, 1'b1, exp_cnt);
    end
    chk("wrap_final_count", {24'd0, cnt_al}, 32'd0);

    // Reset mid-qualification: counter is at 2 after edge 4.
    tick(3);
    btn = 1'b0;
    tick(4);
    chk_all("midq_before_rst", 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b1;
    tick(1);
    chk_all("midq_in_rst", 1'b0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk_all("midq_requalify", 1'b0, 1'b0, 1'b0, 8'd0);
    end
    tick(1);
    chk_all("midq_accept_edge6", 1'b1, 1'b1, 1'b0, 8'd1);
    tick(1);
    chk_all("midq_after", 1'b1, 1'b0, 1'b0, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
